exec_dispatch_queue: RTL



---
 rtl/exec_dispatch_queue.sv | 130 +++++++++++++
 1 files changed

// File: rtl/exec_dispatch_queue.sv
// exec_dispatch_queue
//   In-order dispatch buffer feeding the execution stage's two-lane issue
//   interface. Micro-ops arrive in pairs, sit in a circular FIFO, and are
//   presented oldest-first on two lanes. A lane only goes valid when its
//   functional unit is free and the two lanes do not target the same unit.
//
// Ports
//   clk          in   clock
//   rst_n        in   asynchronous active-low reset
//   in_valid     in   [1:0] push request per lane (lane 0 is older)
//   in_data      in   to_execution[1:0] payloads (.valid ignored on entry)
//   in_ready     out  FIFO can take two ops this cycle
//   busy_fu      in   [FU_NUMBER-1:0] per functional unit busy
//   flush_valid  in   pipeline flush (clears pointers at the clock edge)
//   t_execution  out  to_execution[1:0] dispatched ops (lane 0 is older)
//   occupancy    out  [CNT_BITS-1:0] current entry count

package exec_dispatch_pkg;
  // Functional unit encoding: 0 load/store, 1 floating point, 2 integer, 3 branch
  typedef struct packed {
    logic        valid;
    logic [1:0]  functional_unit;
    logic [5:0]  rob_id;
    logic [31:0] operand;
  } to_execution;
endpackage

module exec_dispatch_queue
  import exec_dispatch_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int FU_NUMBER = 4,
  parameter int CNT_BITS  = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           in_valid,
  input  to_execution [1:0]    in_data,
  output logic                 in_ready,
  input  logic [FU_NUMBER-1:0] busy_fu,
  input  logic                 flush_valid,
  output to_execution [1:0]    t_execution,
  output logic [CNT_BITS-1:0]  occupancy
);

  localparam int PTR_BITS = $clog2(DEPTH);
  localparam logic [CNT_BITS-1:0] DEPTH_C = CNT_BITS'(DEPTH);

  to_execution         mem [DEPTH];
  logic [PTR_BITS-1:0] head;
  logic [PTR_BITS-1:0] tail;
  logic [PTR_BITS-1:0] head_p1;
  logic [PTR_BITS-1:0] tail_p1;
  logic [CNT_BITS-1:0] count;

  logic                push_en;
  logic [1:0]          push_cnt;
  logic [1:0]          pop_cnt;
  to_execution         wr_first;
  to_execution         wr_second;
  logic [1:0]          fu0;
  logic [1:0]          fu1;
  logic                issue0;
  logic                issue1;

  // Pointer arithmetic wraps naturally because DEPTH is a power of two.
  assign head_p1   = head + PTR_BITS'(1);
  assign tail_p1   = tail + PTR_BITS'(1);

  // Only the registered count is used here; same-cycle pops are not credited.
  assign in_ready  = (DEPTH_C - count) >= CNT_BITS'(2);
  assign occupancy = count;

  // Push side: lanes are compacted so a lone lane-1 op still lands at tail.
  always_comb begin
    push_en   = in_ready && !flush_valid && (in_valid != 2'b00);
    push_cnt  = 2'd0;
    if (push_en) begin
      push_cnt = {1'b0, in_valid[0]} + {1'b0, in_valid[1]};
    end
    wr_first        = in_valid[0] ? in_data[0] : in_data[1];
    wr_first.valid  = 1'b0;
    wr_second       = in_data[1];
    wr_second.valid = 1'b0;
  end

  // Dispatch side: lane 1 may only issue alongside lane 0 (strict in-order),
  // and never onto the same unit as lane 0.
  always_comb begin
    fu0    = mem[head].functional_unit;
    fu1    = mem[head_p1].functional_unit;
    issue0 = (count != '0) && !busy_fu[fu0] && !flush_valid;
    issue1 = issue0 && (count >= CNT_BITS'(2)) && (fu1 != fu0) && !busy_fu[fu1];
    pop_cnt = {1'b0, issue0} + {1'b0, issue1};

    t_execution[0]       = mem[head];
    t_execution[0].valid = issue0;
    t_execution[1]       = mem[head_p1];
    t_execution[1].valid = issue1;
  end

  // Storage carries no reset; stale entries are never presented because
  // the valids are qualified by count.
  always_ff @(posedge clk) begin
    if (push_en) begin
      mem[tail] <= wr_first;
      if (in_valid == 2'b11) begin
        mem[tail_p1] <= wr_second;
      end
    end
  end

  // Pointer and count state; flush wins over any push or pop in its cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush_valid) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_BITS'(pop_cnt);
      tail  <= tail + PTR_BITS'(push_cnt);
      count <= count + CNT_BITS'(push_cnt) - CNT_BITS'(pop_cnt);
    end
  end

endmodule
